reg_hazard_scoreboard: RTL and testbench
========================================

# reg_hazard_scoreboard

Parametrised register-hazard scoreboard for the ID stage. It takes the per-instruction register read/write enables and addresses produced by decode and keeps a per-register countdown of cycles until each in-flight result can be forwarded. It raises `stall` when a source or destination conflicts with a pending write. It sits between decode register generation and the ID/EX pipeline register, and replaces fixed load-use interlock logic with latency-aware tracking.

## Interface
- `REG_ADDR_WIDTH`, 5: register address width; `NUM_REGS` = 2**REG_ADDR_WIDTH.
- `NUM_READ`, 2: number of source read ports checked per instruction.
- `MAX_LAT`, 4: maximum result latency in cycles, ≥2; `LAT_W` = clog2(MAX_LAT+1).
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `issue_valid`  in  1  decode holds a valid instruction.
- `read_en`  in  NUM_READ  per-port source enable.
- `read_addr`  in  NUM_READ*REG_ADDR_WIDTH  packed source addresses; port i is at bits [i*W +: W].
- `write_en`  in  1  instruction writes a register.
- `write_addr`  in  REG_ADDR_WIDTH  destination register.
- `issue_lat`  in  LAT_W  cycles until the result is forwardable; 1 = ALU with full forwarding.
- `pipe_hold`  in  1  downstream stall; freezes the scoreboard.
- `flush`  in  1  squash all in-flight writes (branch or exception redirect).
- `stall`  out  1  combinational; holds decode.
- `issue_fire`  out  1  combinational; the instruction is accepted this cycle.
- `pending_mask`  out  NUM_REGS  registered; bit r = 1 when cnt[r] ≠ 0.

## Operation
- State: `cnt[r]` is an LAT_W-bit counter for each register r in 1..NUM_REGS-1. Register 0 is hard-wired to 0 and never pending.
- Effective latency: `L = (issue_lat == 0) ? 1 : min(issue_lat, MAX_LAT)`.
- Read hazard, port i: `read_en[i] && read_addr_i != 0 && cnt[read_addr_i] != 0`.
- WAW hazard: `write_en && write_addr != 0 && cnt[write_addr] > L-1`. This prevents an older long-latency result from overwriting a younger one.
- `stall = issue_valid && (any read hazard || WAW hazard)`. It does not depend on `pipe_hold` or `flush`.
- `issue_fire = issue_valid && !stall && !pipe_hold && !flush`.
- Per-edge update, first matching rule wins:
  1. `flush`: every cnt ← 0, regardless of `pipe_hold`.
  2. `pipe_hold`: every cnt holds.
  3. Otherwise every nonzero cnt decrements by 1. Then, if `issue_fire && write_en && write_addr != 0`, cnt[write_addr] ← L-1, overriding its decrement.
- A write to register 0 or with `write_en` = 0 never changes state. A read of register 0 never stalls.
- `pending_mask` is driven directly from the counters, so it reflects post-edge state.

## Timing
- Reset (rst_n low, asynchronous): all cnt = 0, `pending_mask` = 0. `stall` = 0 and `issue_fire` = `issue_valid && !pipe_hold && !flush` as soon as the counters clear.
- Reset deasserted mid-operation: all in-flight hazards are forgotten. The pipeline is reset together with the scoreboard.
- Producer issued at edge t with latency L: a dependent instruction is accepted no earlier than edge t+L, counting only edges without `pipe_hold`.
  - L=1: no bubble.
  - L=2: one stall cycle.
- Cycles with `pipe_hold` do not count toward latency.
- `flush` and `issue_valid` in the same cycle: the issuing instruction is squashed (`issue_fire` = 0) and the scoreboard ends all-zero.
- A producer and a consumer of the same register cannot issue together. A single instruction reading and writing the same register checks the pre-edge count.
- Counter underflow is impossible because only nonzero counters decrement. A count never exceeds MAX_LAT-1.
- Combinational path: read_addr/write_addr → cnt mux → `stall`. Every output depends only on current inputs and state.

## Test plan
- Reset, then issue write r5 with L=1, then read r5 the next cycle → `stall` = 0, `issue_fire` = 1, `pending_mask` = 0 throughout.
- Load-use: issue write r8 with L=2 at edge t, then read r8 → `pending_mask[8]` = 1 after t; `stall` = 1 for exactly 1 cycle, then fire at t+2.
- `pipe_hold` = 1 for 3 cycles right after issuing r8 with L=3 → cnt[8] frozen at 2 during the hold; the consumer stalls 2 cycles after the hold releases.
- WAW: r3 pending with cnt=3 (issued with L=4), then issue write r3 with L=1 → `stall` = 1 until cnt[3] ≤ 0, then fire; a subsequent r3 reader sees latency 1.
- `flush` while r4, r9 and r31 are pending and `issue_valid` = 1 → `issue_fire` = 0; `pending_mask` = 0 next cycle; a reader of r9 fires immediately.
- Register 0: write r0 with L=4, then read r0 on both ports → no stall, `pending_mask[0]` stays 0. With NUM_READ=3, a hazard on port 2 alone → `stall` = 1.

Source files
------------

// File: rtl/reg_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_hazard_scoreboard
// Description : Latency-aware register hazard scoreboard for the ID stage.
//               Tracks cycles-until-forwardable per register and stalls decode.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_hazard_scoreboard #(
    parameter  int REG_ADDR_WIDTH = 5,
    parameter  int NUM_READ       = 2,
    parameter  int MAX_LAT        = 4,
    localparam int NUM_REGS       = 2**REG_ADDR_WIDTH,
    localparam int LAT_W          = $clog2(MAX_LAT+1)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               issue_valid,
    input  logic [NUM_READ-1:0]                read_en,
    input  logic [NUM_READ*REG_ADDR_WIDTH-1:0] read_addr,
    input  logic                               write_en,
    input  logic [REG_ADDR_WIDTH-1:0]          write_addr,
    input  logic [LAT_W-1:0]                   issue_lat,
    input  logic                               pipe_hold,
    input  logic                               flush,
    output logic                               stall,
    output logic                               issue_fire,
    output logic [NUM_REGS-1:0]                pending_mask
);

    localparam logic [LAT_W-1:0] c_one     = LAT_W'(1);
    localparam logic [LAT_W-1:0] c_max_lat = LAT_W'(MAX_LAT);

    logic [LAT_W-1:0]          w_cnt     [NUM_REGS];
    logic [REG_ADDR_WIDTH-1:0] w_rd_addr [NUM_READ];
    logic [LAT_W-1:0]          w_lat;
    logic [LAT_W-1:0]          w_lat_m1;
    logic                      w_read_hazard;
    logic                      w_waw_hazard;
    logic                      w_stall;
    logic                      w_fire;
    logic                      w_load;

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd_addr
        assign w_rd_addr[i] = read_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
    end

    // Latency 0 is treated as a single-cycle ALU op; oversize values saturate.
    always_comb begin
        if (issue_lat == '0) begin
            w_lat = c_one;
        end else if (issue_lat > c_max_lat) begin
            w_lat = c_max_lat;
        end else begin
            w_lat = issue_lat;
        end
    end

    assign w_lat_m1 = w_lat - c_one;

    always_comb begin
        w_read_hazard = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (read_en[i] && (w_rd_addr[i] != '0) && (w_cnt[w_rd_addr[i]] != '0)) begin
                w_read_hazard = 1'b1;
            end
        end
    end

    // A younger write must not complete before an older in-flight one.
    assign w_waw_hazard = write_en && (write_addr != '0) && (w_cnt[write_addr] > w_lat_m1);

    assign w_stall    = issue_valid && (w_read_hazard || w_waw_hazard);
    assign w_fire     = issue_valid && !w_stall && !pipe_hold && !flush;
    assign w_load     = w_fire && write_en && (write_addr != '0);
    assign stall      = w_stall;
    assign issue_fire = w_fire;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign w_cnt[r]        = '0;
            assign pending_mask[r] = 1'b0;
        end else begin : g_live
            logic [LAT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (flush) begin
                    r_cnt <= '0;
                end else if (!pipe_hold) begin
                    if (w_load && (write_addr == REG_ADDR_WIDTH'(r))) begin
                        r_cnt <= w_lat_m1;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_one;
                    end
                end
            end

            assign w_cnt[r]        = r_cnt;
            assign pending_mask[r] = (r_cnt != '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_hazard_scoreboard
// Description : Directed vector table, corner sequences and randomized
//               stimulus against a ready-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_hazard_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic [1:0]  read_en;
    logic [9:0]  read_addr;
    logic        write_en;
    logic [4:0]  write_addr;
    logic [2:0]  issue_lat;
    logic        pipe_hold;
    logic        flush;
    logic        stall;
    logic        issue_fire;
    logic [31:0] pending_mask;

    logic        issue_valid3;
    logic [2:0]  read_en3;
    logic [14:0] read_addr3;
    logic        write_en3;
    logic [4:0]  write_addr3;
    logic [2:0]  issue_lat3;
    logic        stall3;
    logic        issue_fire3;
    logic [31:0] pending_mask3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_hazard_scoreboard #(.REG_ADDR_WIDTH(5), .NUM_READ(2), .MAX_LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .read_en(read_en),
        .read_addr(read_addr), .write_en(write_en), .write_addr(write_addr),
        .issue_lat(issue_lat), .pipe_hold(pipe_hold), .flush(flush),
        .stall(stall), .issue_fire(issue_fire), .pending_mask(pending_mask)
    );

    reg_hazard_scoreboard #(.REG_ADDR_WIDTH(5), .NUM_READ(3), .MAX_LAT(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid3), .read_en(read_en3),
        .read_addr(read_addr3), .write_en(write_en3), .write_addr(write_addr3),
        .issue_lat(issue_lat3), .pipe_hold(1'b0), .flush(1'b0),
        .stall(stall3), .issue_fire(issue_fire3), .pending_mask(pending_mask3)
    );

    typedef struct {
        logic        v;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic        we;
        logic [4:0]  wa;
        logic [2:0]  lat;
        logic        hold;
        logic        flush;
        logic        exp_stall;
        logic        exp_fire;
        logic [31:0] exp_mask;
    } vec_t;

    vec_t vecs[$];

    // Reference model: absolute forwardable time per register on a clock that
    // only advances on edges without hold.
    int unsigned ready [32];
    int unsigned tnow;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [1:0] re, input logic [4:0] ra0,
                                input logic [4:0] ra1, input logic we, input logic [4:0] wa,
                                input logic [2:0] lat, input logic hold, input logic fl,
                                input logic es, input logic ef, input logic [31:0] em);
        vec_t x;
        x.v = v; x.re = re; x.ra0 = ra0; x.ra1 = ra1; x.we = we; x.wa = wa;
        x.lat = lat; x.hold = hold; x.flush = fl;
        x.exp_stall = es; x.exp_fire = ef; x.exp_mask = em;
        return x;
    endfunction

    function automatic int unsigned rem(input int r);
        if (r == 0 || ready[r] <= tnow) return 0;
        return ready[r] - tnow;
    endfunction

    function automatic int unsigned eff_lat(input logic [2:0] lat);
        if (lat == 0) return 1;
        if (lat > 4) return 4;
        return int'(lat);
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m = '0;
        for (int r = 0; r < 32; r++) m[r] = (rem(r) != 0);
        return m;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready[r] = 0;
        tnow = 0;
    endtask

    task automatic drive(input logic v, input logic [1:0] re, input logic [4:0] ra0,
                         input logic [4:0] ra1, input logic we, input logic [4:0] wa,
                         input logic [2:0] lat, input logic hold, input logic fl);
        issue_valid = v; read_en = re; read_addr = {ra1, ra0};
        write_en = we; write_addr = wa; issue_lat = lat;
        pipe_hold = hold; flush = fl;
    endtask

    task automatic idle3();
        issue_valid3 = 1'b0; read_en3 = '0; read_addr3 = '0;
        write_en3 = 1'b0; write_addr3 = '0; issue_lat3 = 3'd1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] b2, b3, b4, b6, b8, b9, b31;
        b2 = 32'h1 << 2; b3 = 32'h1 << 3; b4 = 32'h1 << 4; b6 = 32'h1 << 6;
        b8 = 32'h1 << 8; b9 = 32'h1 << 9; b31 = 32'h1 << 31;

        //          v  re    ra0 ra1 we wa  lat h  f   st fi mask
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 5, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b01, 5, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 8, 2, 0, 0, 0, 1, b8));
        vecs.push_back(mk(1, 2'b01, 8, 0, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2'b01, 8, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 8, 3, 0, 0, 0, 1, b8));
        vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, b8));
        vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, b8));
        vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 1, 0, 0, 0, b8));
        vecs.push_back(mk(1, 2'b10, 0, 8, 0, 0, 1, 0, 0, 1, 0, b8));
        vecs.push_back(mk(1, 2'b10, 0, 8, 0, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2'b10, 0, 8, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 3, 4, 0, 0, 0, 1, b3));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 3, 1, 0, 0, 1, 0, b3));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 3, 1, 0, 0, 1, 0, b3));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 3, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 3, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b01, 3, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 4, 4, 0, 0, 0, 1, b4));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 9, 3, 0, 0, 0, 1, b4 | b9));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 31, 4, 0, 0, 0, 1, b4 | b9 | b31));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 1, 4, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 9, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 0, 4, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b11, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 2, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 2, 7, 0, 0, 0, 1, b2));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 2, 2, 0, 0, 1, 0, b2));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 2, 2, 0, 0, 1, 0, b2));
        vecs.push_back(mk(1, 2'b00, 0, 0, 1, 2, 2, 0, 0, 0, 1, b2));
        vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 2'b01, 6, 0, 1, 6, 3, 0, 0, 0, 1, b6));
        vecs.push_back(mk(0, 2'b00, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));

        // Reset state, with a valid instruction presented during reset
        rst_n = 1'b0;
        idle3();
        drive(1, 2'b01, 5, 0, 1, 5, 4, 0, 0);
        #1;
        @(posedge clk); #1;
        check("reset_mask", pending_mask, 0);
        check("reset_stall", stall, 0);
        check("reset_fire", issue_fire, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // The valid write above issued on this edge; flush it away
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1);
        @(posedge clk); #1;
        check("post_flush_mask", pending_mask, 0);

        // Directed table
        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].v, vecs[k].re, vecs[k].ra0, vecs[k].ra1, vecs[k].we,
                  vecs[k].wa, vecs[k].lat, vecs[k].hold, vecs[k].flush);
            #1;
            check($sformatf("vec%0d_stall", k), stall, vecs[k].exp_stall);
            check($sformatf("vec%0d_fire", k), issue_fire, vecs[k].exp_fire);
            @(posedge clk); #1;
            check($sformatf("vec%0d_mask", k), pending_mask, vecs[k].exp_mask);
        end

        // Three read ports: hazard seen on port 2 alone
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        issue_valid3 = 1'b1; write_en3 = 1'b1; write_addr3 = 5'd7; issue_lat3 = 3'd3;
        #1;
        check("p3_issue_fire", issue_fire3, 1);
        @(posedge clk); #1;
        check("p3_mask", pending_mask3, 32'h1 << 7);
        write_en3 = 1'b0; read_en3 = 3'b111; read_addr3 = {5'd7, 5'd1, 5'd2};
        #1;
        check("p3_port2_stall", stall3, 1);
        read_en3 = 3'b011;
        #1;
        check("p3_port2_disabled", stall3, 0);
        idle3();

        // Asynchronous reset mid-operation forgets in-flight writes
        drive(1, 0, 0, 0, 1, 10, 4, 0, 0);
        @(posedge clk); #1;
        check("pre_rst_mask", pending_mask, 32'h1 << 10);
        rst_n = 1'b0;
        #1;
        check("async_rst_mask", pending_mask, 0);
        drive(1, 2'b01, 10, 0, 0, 0, 1, 0, 0);
        #1;
        check("async_rst_stall", stall, 0);
        check("async_rst_fire", issue_fire, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk); #1;
        model_reset();

        // Randomized against the reference model
        for (int n = 0; n < 2000; n++) begin
            logic        v, we, hold, fl;
            logic [1:0]  re;
            logic [4:0]  ra [2];
            logic [4:0]  wa;
            logic [2:0]  lat;
            int unsigned l;
            logic        rh, waw, es, ef;
            v    = ($urandom_range(0, 3) != 0);
            re   = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++)
                ra[i] = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            we   = ($urandom_range(0, 2) != 0);
            wa   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
            lat  = 3'($urandom_range(0, 7));
            hold = ($urandom_range(0, 7) == 0);
            fl   = ($urandom_range(0, 15) == 0);

            l   = eff_lat(lat);
            rh  = 1'b0;
            for (int i = 0; i < 2; i++)
                if (re[i] && ra[i] != 0 && rem(int'(ra[i])) != 0) rh = 1'b1;
            waw = we && wa != 0 && rem(int'(wa)) > l - 1;
            es  = v && (rh || waw);
            ef  = v && !es && !hold && !fl;

            drive(v, re, ra[0], ra[1], we, wa, lat, hold, fl);
            #1;
            check("rand_stall", stall, es);
            check("rand_fire", issue_fire, ef);
            @(posedge clk); #1;
            if (fl) begin
                for (int r = 0; r < 32; r++) ready[r] = 0;
            end else if (!hold) begin
                if (ef && we && wa != 0) ready[wa] = tnow + l;
                tnow++;
            end
            check("rand_mask", pending_mask, model_mask());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
